// File: rtl/rv32i_trap_pkg.sv
// Shared types and constants for the rv32i machine-mode trap sequencer.
package rv32i_trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TRAP,
    ST_MRET,
    ST_REDIRECT
  } trap_state_e;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000000B;
  localparam logic [31:0] MCAUSE_MTI = 32'h80000007;

  localparam int MSTATUS_MIE = 3;
  localparam int MIE_MTIE    = 7;
  localparam int MIP_MTIP    = 7;
  localparam int MIE_MEIE    = 11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // External interrupt outranks the timer when both are pending.
  function automatic logic [31:0] irq_cause(input logic ext_pending);
    return ext_pending ? MCAUSE_MEI : MCAUSE_MTI;
  endfunction

endpackage

// File: rtl/rv32i_trap_ctrl_if.sv
// Pipeline / fetch handshakes seen by the trap sequencer.
interface rv32i_trap_ctrl_if;
  logic        exc_valid;
  logic        exc_ready;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        mret_ready;
  logic        drain_req;
  logic        drain_done;
  logic [31:0] resume_pc;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  // master: the trap sequencer; slave: core pipeline and fetch unit
  modport master (
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
    input  drain_done, resume_pc, redirect_ready,
    output exc_ready, mret_ready, drain_req, redirect_valid, redirect_pc
  );

  modport slave (
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
    output drain_done, resume_pc, redirect_ready,
    input  exc_ready, mret_ready, drain_req, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/rv32i_trap_target.sv
// Trap vector computation: direct base, or base + 4*code for vectored interrupts.
module rv32i_trap_target
  import rv32i_trap_pkg::*;
(
  input  logic [31:0] mtvec,
  input  logic        cause_irq,
  input  logic [3:0]  cause_code,
  output logic [31:0] target
);

  logic [31:0] base;

  always_comb begin
    base   = {mtvec[31:2], 2'b00};
    target = base;
    if (mtvec[1:0] == MTVEC_MODE_VECTORED && cause_irq) begin
      target = base + {26'b0, cause_code, 2'b00};
    end
  end

endmodule

// File: rtl/rv32i_trap_ctrl.sv
// Machine-mode trap sequencer: exception > MRET > interrupt, with pipeline drain before interrupts.
//   state    | meaning
//   IDLE     | waiting for exception, MRET or enabled pending interrupt
//   DRAIN    | drain_req high, waiting for empty pipeline or timeout
//   TRAP     | exception_trigger strobe, compute trap vector
//   MRET     | mret_trigger strobe, take mepc
//   REDIRECT | redirect_valid held until fetch accepts
module rv32i_trap_ctrl
  import rv32i_trap_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK     = 32'h00FFFFFF,
  parameter int          DRAIN_TIMEOUT = 16,
  parameter int          CNT_W         = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  rv32i_trap_ctrl_if.master  core,
  input  logic               ext_irq,
  input  logic [31:0]        mstatus_in,
  input  logic [31:0]        mie_in,
  input  logic [31:0]        mip_in,
  input  logic [31:0]        mtvec_in,
  input  logic [31:0]        mepc_in,
  output logic               exception_trigger,
  output logic [31:0]        exception_cause,
  output logic [31:0]        exception_pc,
  output logic [31:0]        exception_value,
  output logic               mret_trigger,
  output logic               busy
);

  trap_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             drain_q;
  logic [31:0]      cause_q, epc_q, tval_q, redirect_pc_q;
  logic [31:0]      trap_target;
  logic             irq_ext, irq_tmr, irq_pend, drain_last;
  logic             exc_ready_c, mret_ready_c, redirect_valid_c;
  logic             unused_csr;

  assign irq_ext    = mstatus_in[MSTATUS_MIE] & mie_in[MIE_MEIE] & ext_irq;
  assign irq_tmr    = mstatus_in[MSTATUS_MIE] & mie_in[MIE_MTIE] & mip_in[MIP_MTIP];
  assign irq_pend   = irq_ext | irq_tmr;
  assign drain_last = (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1));
  assign unused_csr = ^{mstatus_in, mie_in, mip_in};

  rv32i_trap_target u_target (
    .mtvec      (mtvec_in),
    .cause_irq  (cause_q[31]),
    .cause_code (cause_q[3:0]),
    .target     (trap_target)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (core.exc_valid)       state_d = ST_TRAP;
        else if (core.mret_valid) state_d = ST_MRET;
        else if (irq_pend)        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (core.exc_valid)       state_d = ST_TRAP;
        else if (core.drain_done) state_d = irq_pend ? ST_TRAP : ST_IDLE;
        else if (drain_last)      state_d = ST_IDLE;
      end
      ST_TRAP, ST_MRET:           state_d = ST_REDIRECT;
      ST_REDIRECT: begin
        if (core.redirect_ready)  state_d = ST_IDLE;
      end
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Readies are suppressed during reset so nothing is accepted into an aborted sequence.
  always_comb begin
    exc_ready_c       = 1'b0;
    mret_ready_c      = 1'b0;
    exception_trigger = 1'b0;
    mret_trigger      = 1'b0;
    redirect_valid_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        exc_ready_c  = rst_n & core.exc_valid;
        mret_ready_c = rst_n & ~core.exc_valid & core.mret_valid;
      end
      ST_DRAIN:    exc_ready_c       = rst_n;
      ST_TRAP:     exception_trigger = 1'b1;
      ST_MRET:     mret_trigger      = 1'b1;
      ST_REDIRECT: redirect_valid_c  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      tval_q        <= '0;
      redirect_pc_q <= '0;
    end else begin
      cnt_q <= (state_q == ST_DRAIN) ? cnt_q + CNT_W'(1) : '0;
      unique case (state_q)
        ST_IDLE: begin
          if (core.exc_valid) begin
            cause_q <= {28'b0, core.exc_cause};
            epc_q   <= core.exc_pc & ADDR_MASK;
            tval_q  <= core.exc_tval;
          end else if (!core.mret_valid && irq_pend) begin
            drain_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (core.exc_valid) begin
            cause_q <= {28'b0, core.exc_cause};
            epc_q   <= core.exc_pc & ADDR_MASK;
            tval_q  <= core.exc_tval;
            drain_q <= 1'b0;
          end else if (core.drain_done) begin
            if (irq_pend) begin
              cause_q <= irq_cause(irq_ext);
              epc_q   <= core.resume_pc & ADDR_MASK;
              tval_q  <= '0;
            end else begin
              drain_q <= 1'b0;
            end
          end else if (drain_last) begin
            drain_q <= 1'b0;
          end
        end
        ST_TRAP:     redirect_pc_q <= trap_target & ADDR_MASK;
        ST_MRET:     redirect_pc_q <= mepc_in & ADDR_MASK;
        ST_REDIRECT: if (core.redirect_ready) drain_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign core.exc_ready      = exc_ready_c;
  assign core.mret_ready     = mret_ready_c;
  assign core.drain_req      = drain_q;
  assign core.redirect_valid = redirect_valid_c;
  assign core.redirect_pc    = redirect_pc_q;
  assign exception_cause     = cause_q;
  assign exception_pc        = epc_q;
  assign exception_value     = tval_q;
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// Self-checking bench for rv32i_trap_ctrl: directed table, corner sequences, random vectors.
module tb_rv32i_trap_ctrl;

  localparam logic [31:0] MASK = 32'h00FFFFFF;
  localparam int K_EXC  = 0;
  localparam int K_MRET = 1;
  localparam int K_IRQ  = 2;

  typedef struct {
    int          kind;
    logic [3:0]  cause;
    logic [31:0] pc, tval, mtvec, mepc, mie, mip;
    logic        ext;
    logic [31:0] resume;
    int          drain_dly, ready_dly;
    logic [31:0] exp_cause, exp_pc, exp_val, exp_redir;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_trap_ctrl_if core ();
  logic        ext_irq;
  logic [31:0] mstatus_in, mie_in, mip_in, mtvec_in, mepc_in;
  logic        exception_trigger, mret_trigger, busy;
  logic [31:0] exception_cause, exception_pc, exception_value;

  rv32i_trap_ctrl #(.ADDR_MASK(MASK), .DRAIN_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .core(core), .ext_irq(ext_irq),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mip_in(mip_in),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .exception_trigger(exception_trigger), .exception_cause(exception_cause),
    .exception_pc(exception_pc), .exception_value(exception_value),
    .mret_trigger(mret_trigger), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference trap vector: 4-byte aligned base, vectored mode offsets interrupts by 4*code.
  function automatic logic [31:0] model_target(input logic [31:0] mtvec, input logic [31:0] cause);
    longint unsigned t;
    t = mtvec - (mtvec % 4);
    if ((mtvec % 4) == 1 && cause >= 32'h80000000) t = t + 4 * (cause % 16);
    return 32'(t) & MASK;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_cause = 0; r.exp_pc = 0; r.exp_val = 0;
    if (v.kind == K_EXC) begin
      r.exp_cause = 32'(v.cause);
      r.exp_pc    = v.pc & MASK;
      r.exp_val   = v.tval;
      r.exp_redir = model_target(v.mtvec, r.exp_cause);
    end else if (v.kind == K_MRET) begin
      r.exp_redir = v.mepc & MASK;
    end else begin
      r.exp_cause = (v.mie[11] && v.ext) ? 32'h8000000B : 32'h80000007;
      r.exp_pc    = v.resume & MASK;
      r.exp_redir = model_target(v.mtvec, r.exp_cause);
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    mtvec_in = v.mtvec; mepc_in = v.mepc; mie_in = v.mie; mip_in = v.mip; ext_irq = v.ext;
    mstatus_in = (v.kind == K_IRQ) ? 32'h8 : 32'h0;
    if (v.kind == K_EXC) begin
      core.exc_valid = 1'b1; core.exc_cause = v.cause; core.exc_pc = v.pc; core.exc_tval = v.tval;
      #1 chk({tag, ".exc_ready"}, core.exc_ready, 1);
      step();
      core.exc_valid = 1'b0;
    end else if (v.kind == K_MRET) begin
      core.mret_valid = 1'b1;
      #1 chk({tag, ".mret_ready"}, core.mret_ready, 1);
      step();
      core.mret_valid = 1'b0;
    end else begin
      step();
      chk({tag, ".drain_req"}, core.drain_req, 1);
      #1 chk({tag, ".drain_exc_ready"}, core.exc_ready, 1);
      for (int i = 0; i < v.drain_dly; i++) begin
        step();
        chk({tag, ".drain_hold"}, {busy, core.drain_req}, 2'b11);
      end
      core.drain_done = 1'b1; core.resume_pc = v.resume;
      step();
      core.drain_done = 1'b0;
    end
    if (v.kind == K_MRET) begin
      chk({tag, ".strobes"}, {exception_trigger, mret_trigger}, 2'b01);
    end else begin
      chk({tag, ".strobes"}, {exception_trigger, mret_trigger}, 2'b10);
      chk({tag, ".cause"}, exception_cause, v.exp_cause);
      chk({tag, ".pc"}, exception_pc, v.exp_pc);
      chk({tag, ".value"}, exception_value, v.exp_val);
    end
    step();
    mstatus_in = 32'h0;
    chk({tag, ".redir_valid"}, {core.redirect_valid, exception_trigger, mret_trigger}, 3'b100);
    chk({tag, ".redir_pc"}, core.redirect_pc, v.exp_redir);
    for (int i = 0; i < v.ready_dly; i++) begin
      step();
      chk({tag, ".redir_hold"}, core.redirect_pc, core.redirect_valid ? v.exp_redir : 32'hFFFFFFFF);
    end
    core.redirect_ready = 1'b1;
    step();
    core.redirect_ready = 1'b0;
    chk({tag, ".done"}, {busy, core.redirect_valid, core.drain_req}, 3'b000);
  endtask

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   hi;
    core.exc_valid = 0; core.exc_cause = 0; core.exc_pc = 0; core.exc_tval = 0;
    core.mret_valid = 0; core.drain_done = 0; core.resume_pc = 0; core.redirect_ready = 0;
    ext_irq = 0; mstatus_in = 0; mie_in = 0; mip_in = 0; mtvec_in = 0; mepc_in = 0;

    tbl[0] = '{K_EXC, 4'd2, 32'h40, 32'hDEAD, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 3,
               32'h2, 32'h40, 32'hDEAD, 32'h100};
    tbl[1] = '{K_IRQ, 4'd0, 32'h0, 32'h0, 32'h201, 32'h0, 32'h80, 32'h80, 1'b0, 32'h88, 2, 1,
               32'h80000007, 32'h88, 32'h0, 32'h21C};
    tbl[2] = '{K_IRQ, 4'd0, 32'h0, 32'h0, 32'h201, 32'h0, 32'h880, 32'h80, 1'b1, 32'h1234, 0, 0,
               32'h8000000B, 32'h1234, 32'h0, 32'h22C};
    tbl[3] = '{K_MRET, 4'd0, 32'h0, 32'h0, 32'h100, 32'h01000124, 32'h0, 32'h0, 1'b0, 32'h0, 0, 2,
               32'h0, 32'h0, 32'h0, 32'h124};
    tbl[4] = '{K_EXC, 4'd5, 32'hFF001000, 32'h12345678, 32'h301, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0,
               32'h5, 32'h1000, 32'h12345678, 32'h300};
    tbl[5] = '{K_IRQ, 4'd0, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h800, 32'h0, 1'b1, 32'h0A000010, 5, 0,
               32'h8000000B, 32'h10, 32'h0, 32'h1000};

    repeat (2) step();
    chk("reset.ctrl", {busy, core.drain_req, core.redirect_valid, exception_trigger, mret_trigger,
                       core.exc_ready, core.mret_ready}, 7'b0);
    chk("reset.redirect_pc", core.redirect_pc, 0);
    chk("reset.cause", exception_cause, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // exception beats MRET and interrupt in IDLE
    mstatus_in = 32'h8; mie_in = 32'h80; mip_in = 32'h80; mtvec_in = 32'h100;
    core.exc_valid = 1; core.mret_valid = 1; core.exc_cause = 4'hB; core.exc_pc = 32'h44;
    #1 chk("prio.readies", {core.exc_ready, core.mret_ready}, 2'b10);
    step();
    core.exc_valid = 0; core.mret_valid = 0;
    chk("prio.strobes", {exception_trigger, mret_trigger, core.drain_req}, 3'b100);
    chk("prio.cause", exception_cause, 32'hB);
    step();
    mstatus_in = 0;
    core.redirect_ready = 1;
    step();
    core.redirect_ready = 0;
    chk("prio.done", busy, 0);

    // exception arriving while draining for an interrupt
    mstatus_in = 32'h8; mie_in = 32'h880; mip_in = 32'h80; ext_irq = 1; mtvec_in = 32'h201;
    step();
    chk("dexc.drain_req", core.drain_req, 1);
    core.exc_valid = 1; core.exc_cause = 4'd3; core.exc_pc = 32'h500; core.exc_tval = 32'h7;
    #1 chk("dexc.exc_ready", core.exc_ready, 1);
    step();
    core.exc_valid = 0;
    chk("dexc.trig", {exception_trigger, core.drain_req}, 2'b10);
    chk("dexc.cause", exception_cause, 32'h3);
    step();
    mstatus_in = 0; ext_irq = 0;
    chk("dexc.redir_pc", core.redirect_pc, 32'h200);
    core.redirect_ready = 1;
    step();
    core.redirect_ready = 0;
    chk("dexc.done", {busy, core.drain_req}, 2'b00);

    // drain timeout and retry, then interrupt withdrawn before drain_done
    mstatus_in = 32'h8; mie_in = 32'h80; mip_in = 32'h80;
    step();
    hi = 0;
    while (core.drain_req === 1'b1 && hi < 40) begin
      hi++;
      step();
    end
    chk("tmo.cycles", hi, 16);
    chk("tmo.idle", {busy, exception_trigger}, 2'b00);
    step();
    chk("tmo.retry", {busy, core.drain_req}, 2'b11);
    mstatus_in = 0; core.drain_done = 1;
    step();
    core.drain_done = 0;
    chk("tmo.cancel", {busy, core.drain_req, exception_trigger}, 3'b000);
    step();
    chk("tmo.no_trig", {busy, exception_trigger}, 2'b00);

    // reset while a redirect is outstanding
    mtvec_in = 32'h100;
    core.exc_valid = 1; core.exc_cause = 4'd1; core.exc_pc = 32'h80; core.exc_tval = 32'h1;
    step();
    core.exc_valid = 0;
    step();
    chk("rst.in_redirect", core.redirect_valid, 1);
    rst_n = 0;
    step();
    chk("rst.ctrl", {busy, core.drain_req, core.redirect_valid, exception_trigger, mret_trigger}, 5'b0);
    chk("rst.data", core.redirect_pc | exception_cause | exception_pc | exception_value, 0);
    rst_n = 1;
    step();
    chk("rst.after", {busy, exception_trigger, core.redirect_valid}, 3'b000);

    for (int n = 0; n < 40; n++) begin
      v.kind = int'($urandom_range(0, 2));
      v.cause = 4'($urandom); v.pc = $urandom; v.tval = $urandom;
      v.mtvec = $urandom; v.mepc = $urandom; v.resume = $urandom;
      v.mie = $urandom; v.mip = $urandom; v.ext = 1'($urandom);
      if (v.kind == K_IRQ) begin
        case ($urandom_range(0, 2))
          0: begin v.mie[7] = 1; v.mip[7] = 1; end
          1: begin v.mie[11] = 1; v.ext = 1; end
          default: begin v.mie[7] = 1; v.mip[7] = 1; v.mie[11] = 1; v.ext = 1; end
        endcase
        if ($urandom_range(0, 1) == 1) v.mtvec[1:0] = 2'b01;
      end
      v.drain_dly = int'($urandom_range(0, 12));
      v.ready_dly = int'($urandom_range(0, 3));
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32i_trap_ctrl.md
Name: rv32i_trap_ctrl

Overview:
Sequencer for the machine-mode trap path around the rv32i CSR file. It arbitrates between synchronous exceptions, MRET and pending interrupts, and drains the pipeline before taking an interrupt. It drives the CSR file's exception_trigger/mret_trigger strobes and issues a PC redirect to fetch with a valid/ready handshake. It sits between the core pipeline, the CSR file and the fetch unit.

Parameters:
ADDR_MASK, 32'h00FFFFFF, mask applied to every PC driven out (exception_pc, redirect_pc)
DRAIN_TIMEOUT, 16, maximum cycles waited in DRAIN for drain_done before aborting the interrupt attempt
CNT_W, 5, width of the drain counter; must satisfy 2^CNT_W > DRAIN_TIMEOUT

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
exc_valid  in  1  synchronous exception request from execute stage
exc_ready  out  1  exception accepted this cycle
exc_cause  in  4  exception code (mcause[3:0], interrupt bit 0)
exc_pc  in  32  PC of faulting instruction
exc_tval  in  32  mtval value
mret_valid  in  1  MRET executing
mret_ready  out  1  MRET accepted this cycle
ext_irq  in  1  machine external interrupt level (cause 11)
mstatus_in  in  32  from CSR mstatus_out
mie_in  in  32  from CSR mie_out
mip_in  in  32  from CSR mip_out (bit 7 = MTIP)
mtvec_in  in  32  from CSR mtvec_out
mepc_in  in  32  from CSR mepc_out
drain_req  out  1  request pipeline to stop issuing and retire in-flight instructions
drain_done  in  1  pipeline empty; resume_pc valid
resume_pc  in  32  PC of next unexecuted instruction
exception_trigger  out  1  one-cycle strobe to CSR file
exception_cause  out  32  to CSR file
exception_pc  out  32  to CSR file
exception_value  out  32  to CSR file
mret_trigger  out  1  one-cycle strobe to CSR file
redirect_valid  out  1  fetch redirect request
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  32  redirect target
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, drain counter 0, all outputs 0. A reset asserted mid-sequence aborts it; no strobe is issued afterwards.
- States: IDLE, DRAIN, TRAP, MRET, REDIRECT.
- irq_pend = mstatus_in[3] & ((mie_in[11] & ext_irq) | (mie_in[7] & mip_in[7])). External beats timer: cause 32'h8000000B, else 32'h80000007.
- IDLE priority is exception > MRET > interrupt:
  - exc_valid: exc_ready=1 (combinational). Latch cause {28'b0,exc_cause}, exc_pc & ADDR_MASK, and exc_tval. Go to TRAP.
  - else mret_valid: mret_ready=1. Go to MRET.
  - else irq_pend: go to DRAIN, drain_req=1 (registered), clear counter.
- DRAIN: drain_req held high. exc_ready=1 in this state.
  - exc_valid: the exception wins. Drop drain_req, latch exception, go to TRAP.
  - drain_done: re-evaluate irq_pend.
    - Still pending: latch irq cause, resume_pc & ADDR_MASK, value 0. Go to TRAP.
    - Else (masked or cleared meanwhile): return to IDLE.
  - Counter reaches DRAIN_TIMEOUT: drop drain_req, return to IDLE. The interrupt is retried from IDLE.
- TRAP: exception_trigger=1 for exactly one cycle with latched cause/pc/value.
  - Target = mtvec_in & ~3.
  - If mtvec_in[1:0]==2'b01 and cause[31]: target = base + 4*cause[3:0].
  - Register target into redirect_pc; go to REDIRECT.
- MRET: mret_trigger=1 for one cycle; redirect_pc <= mepc_in & ADDR_MASK; go to REDIRECT.
- REDIRECT: redirect_valid=1 and redirect_pc held stable until redirect_ready. Return to IDLE in the cycle after the handshake. drain_req deasserts on the same handshake.
- exc_ready and mret_ready are 0 in TRAP, MRET and REDIRECT; requesters must hold.
- The CSR file clears mstatus.MIE one cycle after exception_trigger. REDIRECT lasts at least one cycle, so IDLE always sees the updated mstatus_in and the same interrupt is never retaken.
- Latency: exception in IDLE at cycle N gives exception_trigger at N+1 and redirect_valid from N+2. MRET has the same timing.
- Arithmetic: 32-bit, wrap ignored (masked by ADDR_MASK).

Decomposition:
- Package rv32i_trap_pkg:
  - state encoding
  - cause constants MCAUSE_MEI=32'h8000000B, MCAUSE_MTI=32'h80000007
  - mstatus/mie/mip bit indices (MIE=3, MTIE/MTIP=7, MEIE=11)
  - MTVEC_MODE_VECTORED=2'b01
- One combinational sub-module, rv32i_trap_target: (mtvec, cause) -> target PC.

Test Plan:
1. mtvec_in=0x100, exc_valid with cause 2, pc 0x40, tval 0xDEAD in IDLE -> N+1: exception_trigger=1, cause=0x2, pc=0x40, value=0xDEAD; then redirect_pc=0x100 until redirect_ready.
2. mstatus_in[3]=1, mie_in=0x80, mip_in=0x80, mtvec_in=0x201 -> drain_req=1; drain_done with resume_pc=0x88 -> cause 0x80000007, pc 0x88, value 0; redirect_pc=0x21C.
3. Timer and external both enabled and pending -> cause 0x8000000B; exc_valid arriving during DRAIN -> exception taken instead, drain_req drops.
4. mret_valid with mepc_in=0x01000124 -> mret_trigger pulse; redirect_pc=0x00000124 (masked).
5. Interrupt pending, drain_done never asserted -> after 16 cycles drain_req=0, IDLE, then re-enters DRAIN next cycle; mstatus_in[3] cleared during DRAIN plus drain_done -> IDLE, no trigger.
6. rst_n low during REDIRECT with redirect_ready=0 -> next cycle all outputs 0, busy=0, no strobe.
